// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: control codes, MIPS opcode/funct values, decoded bundle.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLL = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SRL = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
    localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
    localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
    localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
    localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OP_W-1:0] FN_AND  = 6'h24;
    localparam logic [OP_W-1:0] FN_OR   = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [SHAMT_W-1:0] shamt;
        logic [CTRL_W-1:0]  ctrl;
        logic               illegal;
    } alu_bundle_t;

endpackage

// File: rtl/alu_ctrl_issue_if.sv
// Issue-stage handshake bundle: upstream instruction side and downstream ALU side.
// out_illegal exists only when ALU_ISSUE_ILLEGAL_TRAP_EN is defined.
interface alu_ctrl_issue_if;
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_instr;
    logic [DATA_W-1:0]   in_rs_val;
    logic [DATA_W-1:0]   in_rt_val;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_a;
    logic [DATA_W-1:0]   out_b;
    logic [SHAMT_W-1:0]  out_shamt;
    logic [CTRL_W-1:0]   out_alu_ctrl;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic                out_illegal;

    modport master (
        output in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_shamt, out_alu_ctrl, out_illegal
    );
    modport slave (
        input  in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
        output in_ready, out_valid, out_a, out_b, out_shamt, out_alu_ctrl, out_illegal
    );
`else
    modport master (
        output in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_shamt, out_alu_ctrl
    );
    modport slave (
        input  in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
        output in_ready, out_valid, out_a, out_b, out_shamt, out_alu_ctrl
    );
`endif

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decode of opcode/funct into the ALU control/operand bundle.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output alu_bundle_t       bundle_c
);

    logic [OP_W-1:0]   opcode;
    logic [OP_W-1:0]   funct;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [9:0]        unused_reg_fields;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'h0000, instr[15:0]};
    // Register numbers are resolved upstream; only their values arrive here.
    assign unused_reg_fields = instr[25:16];

    // Illegal encodings fall through to an all-zero bundle with the illegal flag set.
    always_comb begin
        bundle_c         = '0;
        bundle_c.illegal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                bundle_c = '{a: rs_val, b: rt_val, shamt: instr[10:6], ctrl: ALU_AND, illegal: 1'b0};
                case (funct)
                    FN_ADD, FN_ADDU: bundle_c.ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: bundle_c.ctrl = ALU_SUB;
                    FN_AND:          bundle_c.ctrl = ALU_AND;
                    FN_OR:           bundle_c.ctrl = ALU_OR;
                    FN_SLT:          bundle_c.ctrl = ALU_SLT;
                    FN_SLL:          bundle_c.ctrl = ALU_SLL;
                    FN_SRL:          bundle_c.ctrl = ALU_SRL;
                    default: begin
                        bundle_c         = '0;
                        bundle_c.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_LW, OP_SW:
                bundle_c = '{a: rs_val, b: imm_sext, shamt: '0, ctrl: ALU_ADD, illegal: 1'b0};
            OP_SLTI:
                bundle_c = '{a: rs_val, b: imm_sext, shamt: '0, ctrl: ALU_SLT, illegal: 1'b0};
            OP_ANDI:
                bundle_c = '{a: rs_val, b: imm_zext, shamt: '0, ctrl: ALU_AND, illegal: 1'b0};
            OP_ORI:
                bundle_c = '{a: rs_val, b: imm_zext, shamt: '0, ctrl: ALU_OR, illegal: 1'b0};
            OP_BEQ:
                bundle_c = '{a: rs_val, b: rt_val, shamt: '0, ctrl: ALU_SUB, illegal: 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Decode/issue stage: decodes the incoming instruction and queues the bundle in a 2-entry skid buffer.
// ALU_ISSUE_ILLEGAL_TRAP_EN: enqueue illegal instructions and flag them on out_illegal.
module alu_ctrl_issue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    alu_ctrl_issue_if.slave     bus
);

    localparam int unsigned CNT_W = 2;

    alu_bundle_t      dec_c;
    alu_bundle_t      mem_q [DEPTH];
    alu_bundle_t      mem_n [DEPTH];
    alu_bundle_t      out_q;
    alu_bundle_t      out_n;
    logic             head_q, head_n;
    logic             tail_q, tail_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic             in_ready_q, in_ready_n;
    logic             out_valid_q, out_valid_n;
    logic             accept_c, pop_c, enq_c;

    alu_ctrl_decode u_decode (
        .instr    (bus.in_instr),
        .rs_val   (bus.in_rs_val),
        .rt_val   (bus.in_rt_val),
        .bundle_c (dec_c)
    );

    // Next buffer state; the output register preloads the head entry of the next cycle.
    always_comb begin
        mem_n    = mem_q;
        head_n   = head_q;
        tail_n   = tail_q;
        count_n  = count_q;
        out_n    = out_q;
        accept_c = bus.in_valid && in_ready_q && !flush;
        pop_c    = out_valid_q && bus.out_ready;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        enq_c    = accept_c;
`else
        enq_c    = accept_c && !dec_c.illegal;
`endif
        if (flush) begin
            head_n  = 1'b0;
            tail_n  = 1'b0;
            count_n = '0;
        end else begin
            if (enq_c) begin
                mem_n[tail_q] = dec_c;
                tail_n        = ~tail_q;
            end
            if (pop_c) begin
                head_n = ~head_q;
            end
            count_n = count_q + CNT_W'(enq_c) - CNT_W'(pop_c);
        end
        in_ready_n  = (count_n != CNT_W'(DEPTH));
        out_valid_n = (count_n != '0);
        // With nothing left, the fields keep the last popped bundle.
        if (count_n != '0) begin
            out_n = mem_n[head_n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            mem_q       <= mem_n;
            head_q      <= head_n;
            tail_q      <= tail_n;
            count_q     <= count_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            out_q       <= out_n;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_a        = out_q.a;
    assign bus.out_b        = out_q.b;
    assign bus.out_shamt    = out_q.shamt;
    assign bus.out_alu_ctrl = out_q.ctrl;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign bus.out_illegal  = out_q.illegal;
`else
    logic unused_illegal;
    assign unused_illegal = out_q.illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: decode vector table, skid-buffer corner sequences, random traffic vs a queue model.
// Follows ALU_ISSUE_ILLEGAL_TRAP_EN the same way as the design.
module tb_alu_ctrl_issue;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [3:0]  ctrl;
        bit          ill;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [4:0]  eshamt;
        logic [3:0]  ectrl;
        bit          eill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;
    ent_t q[$];

    alu_ctrl_issue_if bus();

    alu_ctrl_issue #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the opcode/funct tables.
    function automatic ent_t model_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        ent_t        e;
        int          op;
        int          fn;
        logic [31:0] imm_s;
        logic [31:0] imm_z;
        op    = int'(ins[31:26]);
        fn    = int'(ins[5:0]);
        imm_z = {16'h0, ins[15:0]};
        imm_s = ins[15] ? (imm_z | 32'hFFFF0000) : imm_z;
        e = '{a: rs, b: 32'h0, shamt: 5'd0, ctrl: 4'd0, ill: 1'b0};
        if (op == 0) begin
            e.b     = rt;
            e.shamt = ins[10:6];
            if (fn == 'h20 || fn == 'h21)      e.ctrl = 4'd2;
            else if (fn == 'h22 || fn == 'h23) e.ctrl = 4'd6;
            else if (fn == 'h24)               e.ctrl = 4'd0;
            else if (fn == 'h25)               e.ctrl = 4'd1;
            else if (fn == 'h2A)               e.ctrl = 4'd7;
            else if (fn == 'h00)               e.ctrl = 4'd3;
            else if (fn == 'h02)               e.ctrl = 4'd4;
            else                               e.ill  = 1'b1;
        end
        else if (op == 'h08 || op == 'h23 || op == 'h2B) begin e.ctrl = 4'd2; e.b = imm_s; end
        else if (op == 'h0A) begin e.ctrl = 4'd7; e.b = imm_s; end
        else if (op == 'h0C) begin e.ctrl = 4'd0; e.b = imm_z; end
        else if (op == 'h0D) begin e.ctrl = 4'd1; e.b = imm_z; end
        else if (op == 'h04) begin e.ctrl = 4'd6; e.b = rt; end
        else e.ill = 1'b1;
        if (e.ill) e = '{a: 32'h0, b: 32'h0, shamt: 5'd0, ctrl: 4'd0, ill: 1'b1};
        return e;
    endfunction

    // One clock: drive at the falling edge, check registered outputs against the model, advance the model.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input bit rdy, input bit fl, input bit r);
        bit   exp_ready;
        bit   exp_valid;
        bit   acc;
        bit   pop;
        ent_t e;
        rst              = r;
        flush            = fl;
        bus.in_valid     = v;
        bus.in_instr     = ins;
        bus.in_rs_val    = rs;
        bus.in_rt_val    = rt;
        bus.out_ready    = rdy;
        #1;
        exp_ready = (q.size() != 2);
        exp_valid = (q.size() != 0);
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("head_a", bus.out_a, q[0].a);
            check("head_b", bus.out_b, q[0].b);
            check("head_shamt", 32'(bus.out_shamt), 32'(q[0].shamt));
            check("head_ctrl", 32'(bus.out_alu_ctrl), 32'(q[0].ctrl));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            check("head_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
`endif
        end
        acc = v && exp_ready && !fl && !r;
        pop = exp_valid && rdy;
        e   = model_decode(ins, rs, rt);
        if (r || fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && (TRAP || !e.ill)) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    vec_t        vecs[$];
    logic [5:0]  ops [10] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h3F, 6'h11};
    logic [5:0]  fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h3F};

    initial begin
        vecs = '{
            '{32'h012A4020, 32'd5,        32'd7,      32'd5,        32'd7,        5'd0, 4'b0010, 1'b0},
            '{32'h3109FFFF, 32'h12345678, 32'h0,      32'h12345678, 32'h0000FFFF, 5'd0, 4'b0000, 1'b0},
            '{32'h2109FFFF, 32'h00000010, 32'h0,      32'h00000010, 32'hFFFFFFFF, 5'd0, 4'b0010, 1'b0},
            '{32'h00094100, 32'h00000033, 32'd1,      32'h00000033, 32'd1,        5'd4, 4'b0011, 1'b0},
            '{32'h000940C2, 32'h00000001, 32'h80,     32'h00000001, 32'h80,       5'd3, 4'b0100, 1'b0},
            '{32'h01095022, 32'd100,      32'd40,     32'd100,      32'd40,       5'd0, 4'b0110, 1'b0},
            '{32'h0109502A, 32'hFFFFFFFF, 32'd2,      32'hFFFFFFFF, 32'd2,        5'd0, 4'b0111, 1'b0},
            '{32'h010950A5, 32'hF0F0F0F0, 32'h0F0F,   32'hF0F0F0F0, 32'h0F0F,     5'd2, 4'b0001, 1'b0},
            '{32'h28008000, 32'd9,        32'h0,      32'd9,        32'hFFFF8000, 5'd0, 4'b0111, 1'b0},
            '{32'h34008000, 32'd9,        32'h0,      32'd9,        32'h00008000, 5'd0, 4'b0001, 1'b0},
            '{32'h8C000004, 32'h1000,     32'h0,      32'h1000,     32'd4,        5'd0, 4'b0010, 1'b0},
            '{32'hAC00FFFC, 32'h1000,     32'h0,      32'h1000,     32'hFFFFFFFC, 5'd0, 4'b0010, 1'b0},
            '{32'h10000003, 32'h55,       32'hABCD,   32'h55,       32'hABCD,     5'd0, 4'b0110, 1'b0},
            '{32'hFC000000, 32'h77,       32'h88,     32'h0,        32'h0,        5'd0, 4'b0000, 1'b1},
            '{32'h0000003F, 32'h77,       32'h88,     32'h0,        32'h0,        5'd0, 4'b0000, 1'b1}
        };

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_rs_val = '0;
        bus.in_rt_val = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_a", bus.out_a, 32'd0);
        check("rst_out_b", bus.out_b, 32'd0);
        check("rst_shamt", 32'(bus.out_shamt), 32'd0);
        check("rst_ctrl", 32'(bus.out_alu_ctrl), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        check("rst_illegal", 32'(bus.out_illegal), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Decode table: one instruction, then inspect the bundle a cycle later.
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt, 1'b1, 1'b0, 1'b0);
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(!vecs[i].eill || TRAP));
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            if (!vecs[i].eill || TRAP) begin
                check($sformatf("vec%0d_a", i), bus.out_a, vecs[i].ea);
                check($sformatf("vec%0d_b", i), bus.out_b, vecs[i].eb);
                check($sformatf("vec%0d_shamt", i), 32'(bus.out_shamt), 32'(vecs[i].eshamt));
                check($sformatf("vec%0d_ctrl", i), 32'(bus.out_alu_ctrl), 32'(vecs[i].ectrl));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                check($sformatf("vec%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].eill));
`endif
            end
            idle(1'b1);
        end

        // Backpressure: three pushes with the ALU stalled; only two fit.
        cycle(1'b1, 32'h012A4020, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h01095022, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 32'h2109FFFF, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0);
        check("full_third_rejected", 32'(q.size()), 32'd2);
        check("stall_hold_a", bus.out_a, 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        check("drain_second_a", bus.out_a, 32'd3);
        check("drain_second_ctrl", 32'(bus.out_alu_ctrl), 32'b0110);
        idle(1'b1);
        idle(1'b1);

        // Flush at count=2 together with a valid input.
        cycle(1'b1, 32'h012A4020, 32'd11, 32'd12, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h012A4020, 32'd13, 32'd14, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h012A4020, 32'd15, 32'd16, 1'b0, 1'b1, 1'b0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        idle(1'b1);

        // Reset mid-operation drops buffered entries.
        cycle(1'b1, 32'h012A4020, 32'd21, 32'd22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h012A4020, 32'd23, 32'd24, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h012A4020, 32'd25, 32'd26, 1'b0, 1'b1, 1'b1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_a", bus.out_a, 32'd0);
        idle(1'b1);

        // Streaming at one per cycle with the ALU always ready.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 32'h20000000 | 32'(i), 32'(i * 3), 32'h0, 1'b1, 1'b0, 1'b0);
        end
        idle(1'b1);

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 9)];
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 9)];
            cycle(($urandom % 4) != 0, ins, $urandom, $urandom, ($urandom % 3) != 0,
                  ($urandom % 40) == 0, ($urandom % 97) == 0);
        end
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
